rose_window_checker: RTL
========================

Name: rose_window_checker

Overview:
- Synthesizable, multi-channel checker for the property "a |-> ##[DELAY_MIN:DELAY_MAX] $rose(b)".
- Runs one independent checker per channel, with overlapping attempts tracked separately, as concurrent SVA threads do.
- Sits beside a DUT in simulation benches and FPGA debug builds; reports per-channel pass/fail pulses, saturating fail counts and a sticky error.

Parameters:
- CHANNELS, 4, number of independent a/b channel pairs (1..32).
- DELAY_MIN, 2, earliest cycle after the antecedent at which the rise may occur (0..DELAY_MAX).
- DELAY_MAX, 2, latest cycle after the antecedent at which the rise may occur (DELAY_MIN..16).
- CNT_W, 8, width of each per-channel saturating fail counter.

Ports:
- clk  in  1  clock; all sampling on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  CHANNELS  per-channel enable; gates new attempts only.
- clr  in  1  synchronous clear of counters, sticky error and pending attempts; b history is kept.
- a  in  CHANNELS  antecedent per channel.
- b  in  CHANNELS  consequent per channel.
- pass_o  out  CHANNELS  one-cycle pulse: at least one attempt satisfied.
- fail_o  out  CHANNELS  one-cycle pulse: one attempt expired unsatisfied.
- busy_o  out  CHANNELS  at least one attempt pending.
- fail_cnt_o  out  CHANNELS*CNT_W  packed saturating fail counts; channel i occupies bits [i*CNT_W +: CNT_W].
- err_o  out  1  sticky OR of all fail events.

Behaviour:
- Reset: every output is 0, every pending bit is 0 and b_prev is 0.
- Sampling and age:
  - At each posedge, per channel, A[0] = a & en and A[k] = pend[k] for k = 1..DELAY_MAX.
  - pend[k] means "attempt started k edges ago, still unsatisfied".
  - rose = b & ~b_prev, and b_prev <= b every edge.
- Satisfaction: if rose, every A[k] with DELAY_MIN <= k <= DELAY_MAX is satisfied and cleared. One rise satisfies all in-window attempts at once.
- Expiry: if A[DELAY_MAX] is set and rose is 0, that attempt fails. At most one fail per channel per edge.
- Shift: pend[k+1] <= A[k] & ~(rose & (k in window)) for k < DELAY_MAX. pend[DELAY_MAX] is consumed every edge, whether it passed or failed.
- Zero-delay case: DELAY_MIN = 0 allows a rise on the antecedent edge itself. With DELAY_MAX = 0 the attempt is decided on the same edge.
- Latency: pass_o and fail_o are registered and assert in the cycle following the deciding edge, for exactly one cycle.
- Counters:
  - fail_cnt increments by 1 on each fail and holds at 2^CNT_W-1.
  - err_o sets on any fail and clears only via rst or clr.
- Simultaneous events:
  - A pass and a fail on the same edge in one channel are both reported (different attempts).
  - When clr and a fail occur together, clr wins: the counter goes to 0 and err_o to 0.
- en low: no new attempts, pending ones continue to resolve.
- Reset or clr mid-operation discards pending attempts silently, with no fail reported.
- busy_o = OR of pend[1..DELAY_MAX], registered.
- Parameter guard: an elaboration-time error is raised if DELAY_MIN > DELAY_MAX, DELAY_MAX > 16 or CHANNELS > 32.

Optional Feature:
- Macro: ROSE_CHK_FIRST_FAIL_EN.
- When defined, two extra outputs are added:
  - first_fail_vld_o (1 bit),
  - first_fail_ch_o ($clog2(CHANNELS) bits, minimum 1).
- These capture the lowest-index channel failing on the first fail edge after rst/clr. They hold until rst/clr, and later fails do not overwrite them.
- When not defined, the ports and logic are absent and all other behaviour is identical.

Test Plan:
- MIN=MAX=2, ch0: edges 0-1 a=1 b=1 (b rises at edge 0), edges 2-3 a=0 b=0 -> no pass; fail_o[0] pulses after edges 2 and 3; fail_cnt[0]=2; err_o=1.
- MIN=MAX=2: a=1 at edges 0-1, b rises at edge 2 and stays high -> pass_o[0] after edge 2, fail_o[0] after edge 3, fail_cnt[0]=1.
- MIN=1, MAX=3: a=1 at edge 0 only, b rises at edge 3 -> pass_o after edge 3, no fail; busy_o=1 for cycles after edges 0-2, then 0.
- CNT_W=2: 5 separate failing attempts on ch1 -> fail_cnt[1] saturates at 3; err_o=1; then clr -> count 0, err_o 0; channels 0, 2 and 3 untouched throughout.
- MIN=MAX=2: a=1 at edge 0, rst at edge 1, b never rises -> no fail_o, all outputs 0 after edge 1; same sequence with en[0]=0 -> no attempt, busy_o[0]=0.
- With ROSE_CHK_FIRST_FAIL_EN, MIN=MAX=2: ch2 and ch3 fail on the same edge, ch0 fails later -> first_fail_ch_o=2 and first_fail_vld_o=1, both held.

Source files
------------

// File: rtl/rose_window_checker.sv
// Multi-channel checker for "a |-> ##[DELAY_MIN:DELAY_MAX] $rose(b)", one attempt tracker per age slot.
// Define ROSE_CHK_FIRST_FAIL_EN to add first_fail_vld_o/first_fail_ch_o capture of the first failing channel.
module rose_window_checker #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DELAY_MIN = 2,
  parameter int unsigned DELAY_MAX = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  output logic [CHANNELS-1:0]       pass_o,
  output logic [CHANNELS-1:0]       fail_o,
  output logic [CHANNELS-1:0]       busy_o,
  output logic [CHANNELS*CNT_W-1:0] fail_cnt_o,
  output logic                      err_o
`ifdef ROSE_CHK_FIRST_FAIL_EN
  ,
  output logic                                             first_fail_vld_o,
  output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] first_fail_ch_o
`endif
);

  if (DELAY_MIN > DELAY_MAX || DELAY_MAX > 16 || CHANNELS > 32 || CHANNELS < 1) begin : g_param_err
    $error("rose_window_checker: illegal parameters CHANNELS=%0d DELAY_MIN=%0d DELAY_MAX=%0d",
           CHANNELS, DELAY_MIN, DELAY_MAX);
  end

  typedef logic [DELAY_MAX:0] age_t;

  function automatic age_t win_mask();
    age_t m;
    m = '0;
    for (int unsigned k = 0; k <= DELAY_MAX; k++) begin
      if (k >= DELAY_MIN) m[k] = 1'b1;
    end
    return m;
  endfunction

  localparam age_t WIN = win_mask();

  // Bit 0 of pend_q is never set; it is overwritten by the new attempt when building att.
  age_t                pend_q [CHANNELS];
  age_t                pend_n [CHANNELS];
  age_t                att    [CHANNELS];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CHANNELS-1:0] b_prev_q;
  logic [CHANNELS-1:0] rose;
  logic [CHANNELS-1:0] pass_evt;
  logic [CHANNELS-1:0] fail_evt;
  logic [CHANNELS-1:0] busy_n;

  always_comb begin
    rose     = b & ~b_prev_q;
    pass_evt = '0;
    fail_evt = '0;
    busy_n   = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      att[ch]    = pend_q[ch];
      att[ch][0] = a[ch] & en[ch];
      pend_n[ch] = '0;
      for (int unsigned k = 0; k < DELAY_MAX; k++) begin
        pend_n[ch][k+1] = att[ch][k] & ~(rose[ch] & WIN[k]);
      end
      pass_evt[ch] = rose[ch] & (|(att[ch] & WIN));
      fail_evt[ch] = att[ch][DELAY_MAX] & ~rose[ch];
      busy_n[ch]   = |pend_n[ch];
    end
  end

  always_comb begin
    fail_cnt_o = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      fail_cnt_o[ch*CNT_W +: CNT_W] = cnt_q[ch];
    end
  end

  // clr takes priority over same-edge events, so pending attempts vanish without a fail pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_prev_q <= '0;
      pend_q   <= '{default: '0};
      cnt_q    <= '{default: '0};
      pass_o   <= '0;
      fail_o   <= '0;
      busy_o   <= '0;
      err_o    <= 1'b0;
    end else begin
      b_prev_q <= b;
      if (clr) begin
        pend_q <= '{default: '0};
        cnt_q  <= '{default: '0};
        pass_o <= '0;
        fail_o <= '0;
        busy_o <= '0;
        err_o  <= 1'b0;
      end else begin
        pend_q <= pend_n;
        pass_o <= pass_evt;
        fail_o <= fail_evt;
        busy_o <= busy_n;
        if (|fail_evt) err_o <= 1'b1;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
          if (fail_evt[ch] && cnt_q[ch] != '1) cnt_q[ch] <= cnt_q[ch] + 1'b1;
        end
      end
    end
  end

`ifdef ROSE_CHK_FIRST_FAIL_EN
  localparam int unsigned FF_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [FF_W-1:0] ff_ch_n;

  always_comb begin
    ff_ch_n = '0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (fail_evt[i-1]) ff_ch_n = FF_W'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      first_fail_vld_o <= 1'b0;
      first_fail_ch_o  <= '0;
    end else if (!first_fail_vld_o && |fail_evt) begin
      first_fail_vld_o <= 1'b1;
      first_fail_ch_o  <= ff_ch_n;
    end
  end
`endif

endmodule
